// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: LFSR geometry, the common seed used by the
// generator and its benches, and the checker state encoding.
package prbs_pkg;

  localparam int PRBS_WIDTH = 48;
  localparam int PRBS_TAP_A = 47;
  localparam int PRBS_TAP_B = 35;
  localparam logic [PRBS_WIDTH-1:0] PRBS_SEED = 48'h1234_5678_9ABC;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // One step of the Fibonacci LFSR: feedback bit enters at the LSB.
  function automatic logic [PRBS_WIDTH-1:0] prbs_advance(input logic [PRBS_WIDTH-1:0] s);
    return {s[PRBS_WIDTH-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Loss-of-sync detector: counts valid beats in a fixed window and the errors
// seen inside it; raises loss on the beat whose error reaches the threshold.
module prbs_err_window #(
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic beat,
  input  logic err,
  output logic loss
);

  localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam int SW = EW + 1;

  logic [BW-1:0] win_bits;
  logic [EW-1:0] win_err;
  logic          wrap;
  logic [SW-1:0] err_base;
  logic [SW-1:0] err_sum;

  // Error total for this beat; an error on the wrap beat starts the new window.
  always_comb begin
    wrap     = (win_bits == BW'(WINDOW - 1));
    err_base = wrap ? {SW{1'b0}} : {1'b0, win_err};
    err_sum  = err_base + SW'(err);
    loss     = beat & err & (err_sum >= SW'(LOSS_THRESH));
  end

  // Window counters; held clear whenever the checker is not locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_bits <= {BW{1'b0}};
      win_err  <= {EW{1'b0}};
    end else if (restart) begin
      win_bits <= {BW{1'b0}};
      win_err  <= {EW{1'b0}};
    end else if (beat) begin
      win_bits <= wrap ? {BW{1'b0}} : (win_bits + BW'(1));
      if (err_sum >= SW'(LOSS_THRESH)) begin
        win_err <= EW'(LOSS_THRESH);
      end else begin
        win_err <= err_sum[EW-1:0];
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a shadow LFSR to the received stream,
// declares lock after a run of correct predictions, then flags and counts
// bit errors, dropping lock when too many errors land in one window.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH       = PRBS_WIDTH,
  parameter int TAP_A       = PRBS_TAP_A,
  parameter int TAP_B       = PRBS_TAP_B,
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             bit_err,
  output logic             sync_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  prbs_state_t      state;
  prbs_state_t      state_next;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_next;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] err_next;
  logic             bit_err_next;
  logic             sync_lost_next;
  logic             pred;
  logic             match;
  logic             win_beat;
  logic             win_restart;
  logic             loss;

  // Window error accounting only runs while locked.
  prbs_err_window #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_err_window (
    .clk     (clk),
    .reset   (reset),
    .restart (win_restart),
    .beat    (win_beat),
    .err     (~match),
    .loss    (loss)
  );

  // Prediction of the incoming bit from the shadow LFSR.
  always_comb begin
    pred        = shadow[TAP_A] ^ shadow[TAP_B];
    match       = (bit_in == pred);
    win_restart = (state != LOCKED);
    win_beat    = bit_valid & (state == LOCKED);
  end

  // Next-state, shadow update and error bookkeeping for one valid beat.
  always_comb begin
    state_next     = state;
    shadow_next    = shadow;
    fill_next      = fill_cnt;
    good_next      = good_cnt;
    err_inc        = err_count;
    bit_err_next   = 1'b0;
    sync_lost_next = 1'b0;
    if (bit_valid) begin
      case (state)
        FILL: begin
          shadow_next = {shadow[WIDTH-2:0], bit_in};
          if (fill_cnt == FILL_W'(WIDTH - 1)) begin
            fill_next = {FILL_W{1'b0}};
            // An all-zero shadow would predict zeros forever; keep filling.
            if (shadow_next == {WIDTH{1'b0}}) begin
              state_next = FILL;
            end else begin
              state_next = VERIFY;
              good_next  = {GOOD_W{1'b0}};
            end
          end else begin
            fill_next = fill_cnt + FILL_W'(1);
          end
        end
        VERIFY: begin
          shadow_next = {shadow[WIDTH-2:0], bit_in};
          if (match) begin
            if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
              state_next = LOCKED;
              good_next  = {GOOD_W{1'b0}};
            end else begin
              good_next = good_cnt + GOOD_W'(1);
            end
          end else begin
            state_next = FILL;
            fill_next  = {FILL_W{1'b0}};
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one flipped bit costs one error.
          shadow_next = {shadow[WIDTH-2:0], pred};
          if (!match) begin
            bit_err_next = 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
              err_inc = err_count + CNT_W'(1);
            end else begin
              err_inc = err_count;
            end
          end else begin
            bit_err_next = 1'b0;
          end
          if (loss) begin
            state_next     = FILL;
            fill_next      = {FILL_W{1'b0}};
            sync_lost_next = 1'b1;
          end else begin
            sync_lost_next = 1'b0;
          end
        end
        default: begin
          state_next = FILL;
          fill_next  = {FILL_W{1'b0}};
          good_next  = {GOOD_W{1'b0}};
        end
      endcase
    end else begin
      state_next = state;
    end
    // A clear wins over a same-cycle increment.
    err_next = clr_err ? {CNT_W{1'b0}} : err_inc;
  end

  // State, shadow, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      shadow    <= {WIDTH{1'b0}};
      fill_cnt  <= {FILL_W{1'b0}};
      good_cnt  <= {GOOD_W{1'b0}};
      err_count <= {CNT_W{1'b0}};
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_next;
      shadow    <= shadow_next;
      fill_cnt  <= fill_next;
      good_cnt  <= good_next;
      err_count <= err_next;
      locked    <= (state_next == LOCKED);
      bit_err   <= bit_err_next;
      sync_lost <= sync_lost_next;
    end
  end

endmodule
